// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and byte/word widths for rom_loader.
// The CHK_* states exist only when ROM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
    CHK_LO,
    CHK_HI,
`endif
    DONE
  } state_t;
endpackage

// File: rtl/rom_loader.sv
// rom_loader: assembles a little-endian byte stream into 16-bit words with write strobes.
// Optional trailing checksum check enabled by ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       out,
  output logic              load,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state, nxt;
  logic [WORD_W-1:0] cnt, idx;
  logic [BYTE_W-1:0] lo;
  logic accept, last, idle;
  assign accept = in_valid & in_ready;
  assign last   = (idx + 16'd1) == cnt;
  assign idle   = (state == IDLE) || (state == DONE);
  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    load     = 1'b0;
    busy     = !idle;
    done     = state == DONE;
    case (state)
      IDLE, DONE: if (start) nxt = (word_count == 16'd0) ? DONE : LO;
      LO: begin
        in_ready = 1'b1;
        if (accept) nxt = HI;
      end
      HI: begin
        in_ready = 1'b1;
        if (accept) nxt = WRITE;
      end
      WRITE: begin
        load = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
        nxt = last ? CHK_LO : LO;
`else
        nxt = last ? DONE : LO;
`endif
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK_LO: begin
        in_ready = 1'b1;
        if (accept) nxt = CHK_HI;
      end
      CHK_HI: begin
        in_ready = 1'b1;
        if (accept) nxt = DONE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      lo    <= '0;
      out   <= '0;
      addr  <= '0;
    end else begin
      state <= nxt;
      if (idle && start) begin
        cnt  <= word_count;
        idx  <= '0;
        addr <= '0;
      end
      if (accept && state != HI) lo <= in_data;
      if (accept && state == HI) out <= {in_data, lo};
      if (state == WRITE) begin
        addr <= addr + ADDR_W'(1);
        idx  <= idx + 16'd1;
      end
    end
  end
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (idle && start) begin
        sum <= '0;
        err <= 1'b0;
      end
      if (state == WRITE) sum <= sum + out;
      if (accept && state == CHK_HI) err <= {in_data, lo} != sum;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven and hand-sequenced checks of rom_loader against a word-list model.
// Two instances share stimulus: default ADDR_W and ADDR_W=2 for address wrap.
module tb_rom_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [15:0] word_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, load, busy, done, err;
  logic [15:0] out;
  logic [14:0] addr;
  logic        in_ready2, load2, busy2, done2, err2;
  logic [15:0] out2;
  logic [1:0]  addr2;
  int checks = 0, errors = 0;
  logic [15:0] wq[$];
  logic [31:0] obs[$], obs2[$];

  rom_loader dut (.clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out(out), .load(load),
    .addr(addr), .busy(busy), .done(done), .err(err));
  rom_loader #(.ADDR_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2), .out(out2), .load(load2),
    .addr(addr2), .busy(busy2), .done(done2), .err(err2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load) obs.push_back({1'b0, addr, out});
    if (load2) obs2.push_back({14'b0, addr2, out2});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      if (poke && g == 0) begin
        start = 1'b1;
        word_count = 16'd0;
      end
      @(negedge clk);
      start = 1'b0;
      if (!load) chk("stall in_ready", 32'(in_ready), 32'd1);
      chk("stall busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("in_ready timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic session(input int gap, input int chk_delta, input bit poke);
    int n, t;
    logic [15:0] sum, cs;
    logic exp_err;
    n = wq.size();
    sum = '0;
    exp_err = 1'b0;
    obs.delete();
    obs2.delete();
    @(negedge clk);
    word_count = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) chk("wc0 done next cycle", 32'(done), 32'd1);
    else chk("busy after start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      send_byte(wq[i][7:0], gap, poke);
      send_byte(wq[i][15:8], gap, 1'b0);
      sum += wq[i];
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    if (n != 0) begin
      cs = sum + 16'(chk_delta);
      send_byte(cs[7:0], gap, 1'b0);
      send_byte(cs[15:8], gap, 1'b0);
      exp_err = chk_delta != 0;
    end
`else
    cs = 16'(chk_delta);
`endif
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("done held", 32'(done), 32'd1);
    chk("busy after done", 32'(busy), 32'd0);
    chk("err", 32'(err), 32'(exp_err));
    chk("load count", 32'(obs.size()), 32'(n));
    chk("load count w2", 32'(obs2.size()), 32'(n));
    for (int i = 0; i < n && i < obs.size(); i++)
      chk($sformatf("write %0d", i), obs[i], {1'b0, 15'(i), wq[i]});
    for (int i = 0; i < n && i < obs2.size(); i++)
      chk($sformatf("write w2 %0d", i), obs2[i], {14'b0, 2'(i), wq[i]});
  endtask

  typedef struct {
    int n;
    int gap;
    bit poke;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1, 0, 1'b0};
    tbl[1] = '{3, 1, 1'b0};
    tbl[2] = '{4, 3, 1'b1};
    tbl[3] = '{6, 2, 1'b0};
    tbl[4] = '{2, 0, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset out", 32'(out), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle stays idle", 32'(busy), 32'd0);
    wq = '{16'h1234, 16'hABCD};
    session(0, 0, 1'b0);
    chk("out holds last word", 32'(out), 32'h0000ABCD);
    chk("load low after done", 32'(load), 32'd0);
    session(3, 0, 1'b0);
    wq.delete();
    session(0, 0, 1'b0);
    for (int v = 0; v < 5; v++) begin
      wq.delete();
      for (int i = 0; i < tbl[v].n; i++) wq.push_back(16'($urandom));
      session(tbl[v].gap, 0, tbl[v].poke);
    end
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
    session(1, 0, 1'b0);
    if (obs2.size() == 5) chk("w2 wrap addr", {30'b0, obs2[4][17:16]}, 32'd0);
    else chk("w2 wrap count", 32'(obs2.size()), 32'd5);
    wq = '{16'h0001, 16'hFFFF};
    session(0, 0, 1'b0);
    session(0, 1, 1'b0);
    wq = '{16'h5A01, 16'hC3E7, 16'h0F0F};
    @(negedge clk);
    word_count = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'hE7, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst out", 32'(out), 32'd0);
    chk("rst addr", 32'(addr), 32'd0);
    chk("rst load", 32'(load), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle after reset", 32'(busy), 32'd0);
    session(0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
